bus_rr_scheduler: RTL and testbench
===================================

Name: bus_rr_scheduler

Overview:
- Grant scheduler in front of the serial system bus. Replaces fixed-priority master selection with round-robin arbitration across NUM_MASTERS requesters.
- Enforces a grant-to-start timeout and a maximum tenure per grant, inserts a one-cycle turnaround between owners, and reports timeouts.
- Sits between the masters' breq/bgrant handshakes and the bus arbiter's per-master datapath mux, which it steers via owner.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
IDX_W, 2, width of owner index; must equal clog2(NUM_MASTERS), minimum 1
START_TIMEOUT, 16, cycles a granted master has to raise master_valid (>=2)
MAX_TENURE, 64, max cycles in BUSY per grant (>=2, <=256)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
breq  in  NUM_MASTERS  per-master bus request, held for the whole tenure
master_valid  in  NUM_MASTERS  per-master master_valid; owner's bit marks transaction start
txn_done  in  1  one-cycle pulse from bus arbiter: current transaction finished (its CLEAN state)
bgrant  out  NUM_MASTERS  registered one-hot grant, or all zero
owner  out  IDX_W  registered index of current/last granted master; drives the arbiter mux select
bus_busy  out  1  registered, 1 whenever state != IDLE
timeout_pulse  out  1  registered one-cycle pulse on a forced release
timeout_id  out  IDX_W  index of the master forced off; valid with timeout_pulse, holds until the next timeout
timeout_cnt  out  8  count of forced releases, saturates at 255

Behaviour:
- Reset (rst=1 at an edge, including mid-tenure):
  - state=IDLE; bgrant=0; owner=0; bus_busy=0; timeout_pulse=0; timeout_id=0; timeout_cnt=0.
  - Internal last_owner=NUM_MASTERS-1, so master 0 wins the first contention; wait_cnt=0; ten_cnt=0.
- States: IDLE, GRANT, BUSY, RELEASE.
- IDLE: if any breq bit is set, pick the first requester scanning last_owner+1, +2, ... modulo NUM_MASTERS. Next edge: owner=pick, bgrant=one-hot(pick), wait_cnt=0, go to GRANT. Grant latency is 1 cycle from breq sampled in IDLE.
- GRANT, priority order:
  1. breq[owner]=0 → RELEASE (abandon, no timeout).
  2. master_valid[owner]=1 → BUSY, ten_cnt=0.
  3. wait_cnt==START_TIMEOUT-1 → RELEASE with timeout.
  4. Otherwise wait_cnt+1.
- BUSY, priority order:
  1. txn_done=1 → RELEASE.
  2. breq[owner]=0 → RELEASE.
  3. ten_cnt==MAX_TENURE-1 → RELEASE with timeout.
  4. Otherwise ten_cnt+1.
- Timeout release, on the same edge as entering RELEASE:
  - bgrant=0; timeout_pulse=1 for exactly one cycle; timeout_id=owner; timeout_cnt+1 unless already 255.
- Every entry to RELEASE clears bgrant on that edge. While in RELEASE, bgrant=0, so the bus sees a one-cycle turnaround.
- RELEASE: last_owner=owner → IDLE unconditionally (1 cycle). Minimum spacing between two grants is 2 cycles with bgrant low.
- owner holds its value through RELEASE and IDLE.
- master_valid and breq bits of non-owners are ignored outside IDLE. A new request never pre-empts the current owner.
- txn_done in IDLE, GRANT or RELEASE is ignored.
- Simultaneous txn_done and tenure expiry: txn_done wins, no timeout.
- Invariants: bgrant has at most one bit set, and never a bit other than owner.

Test Plan:
- Reset, then breq=4'b0001 → bgrant=0001 one cycle after IDLE sample, owner=0. master_valid[0] next cycle → BUSY. txn_done → bgrant=0000 next edge, bus_busy=0 two cycles later.
- breq=4'b1111 held, each master raises master_valid on grant and gets txn_done after 5 cycles → grant order 0,1,2,3,0; each handover shows exactly 1 RELEASE cycle with bgrant=0.
- breq=4'b0100, master 2 never raises master_valid → bgrant[2] high for 16 cycles, then cleared; timeout_pulse=1 for one cycle, timeout_id=2, timeout_cnt=1.
- Owner 1 in BUSY, no txn_done for 64 cycles → forced release on cycle 64, timeout_id=1. Repeat 300 times → timeout_cnt saturates at 255.
- txn_done asserted on the same cycle ten_cnt==63 → normal release, timeout_pulse stays 0, timeout_cnt unchanged.
- rst=1 pulsed mid-BUSY with owner=3 → next edge: bgrant=0, owner=0, bus_busy=0. After release of rst with breq=1111 → master 0 granted first.

Source files
------------

// File: rtl/bus_rr_scheduler.sv
// Round-robin grant scheduler for the serial system bus: one owner at a time,
// start timeout, tenure limit, one-cycle turnaround and timeout reporting.
module bus_rr_scheduler #(
    parameter int unsigned NUM_MASTERS   = 4,
    parameter int unsigned IDX_W         = 2,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned MAX_TENURE    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic [NUM_MASTERS-1:0] master_valid,
    input  logic                   txn_done,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy,
    output logic                   timeout_pulse,
    output logic [IDX_W-1:0]       timeout_id,
    output logic [7:0]             timeout_cnt
);

    localparam int unsigned WAIT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned TEN_W  = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
    localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);
    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
    localparam logic [TEN_W-1:0]       TEN_LAST  = TEN_W'(MAX_TENURE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] bgrant_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       last_owner_q;
    logic                   bus_busy_q;
    logic                   timeout_pulse_q;
    logic [IDX_W-1:0]       timeout_id_q;
    logic [7:0]             timeout_cnt_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic [TEN_W-1:0]       ten_cnt_q;
    logic [IDX_W-1:0]       pick_d;

    // First requester after last_owner, scanning upward with wrap-around.
    always_comb begin : pick_logic
        int unsigned idx;
        logic        found;
        pick_d = last_owner_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = 32'(last_owner_q) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && breq[IDX_W'(idx)]) begin
                pick_d = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bgrant_q        <= '0;
            owner_q         <= '0;
            last_owner_q    <= IDX_W'(NUM_MASTERS - 1);
            bus_busy_q      <= 1'b0;
            timeout_pulse_q <= 1'b0;
            timeout_id_q    <= '0;
            timeout_cnt_q   <= '0;
            wait_cnt_q      <= '0;
            ten_cnt_q       <= '0;
        end else begin
            timeout_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|breq) begin
                        state_q    <= S_GRANT;
                        owner_q    <= pick_d;
                        bgrant_q   <= GRANT_ONE << pick_d;
                        wait_cnt_q <= '0;
                        bus_busy_q <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!breq[owner_q]) begin
                        state_q  <= S_RELEASE;
                        bgrant_q <= '0;
                    end else if (master_valid[owner_q]) begin
                        state_q   <= S_BUSY;
                        ten_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q         <= S_RELEASE;
                        bgrant_q        <= '0;
                        timeout_pulse_q <= 1'b1;
                        timeout_id_q    <= owner_q;
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_BUSY: begin
                    // txn_done outranks tenure expiry, so a finishing transaction is never flagged.
                    if (txn_done || !breq[owner_q]) begin
                        state_q  <= S_RELEASE;
                        bgrant_q <= '0;
                    end else if (ten_cnt_q == TEN_LAST) begin
                        state_q         <= S_RELEASE;
                        bgrant_q        <= '0;
                        timeout_pulse_q <= 1'b1;
                        timeout_id_q    <= owner_q;
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                    end else begin
                        ten_cnt_q <= ten_cnt_q + TEN_W'(1);
                    end
                end
                S_RELEASE: begin
                    state_q      <= S_IDLE;
                    last_owner_q <= owner_q;
                    bus_busy_q   <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    bgrant_q   <= '0;
                    bus_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bgrant        = bgrant_q;
    assign owner         = owner_q;
    assign bus_busy      = bus_busy_q;
    assign timeout_pulse = timeout_pulse_q;
    assign timeout_id    = timeout_id_q;
    assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: vector table plus multi-cycle sequences.
module tb_bus_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] breq;
    logic [3:0] master_valid;
    logic       txn_done;
    logic [3:0] bgrant;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_pulse;
    logic [1:0] timeout_id;
    logic [7:0] timeout_cnt;

    int n_vec = 0;
    int n_err = 0;

    bus_rr_scheduler #(
        .NUM_MASTERS  (4),
        .IDX_W        (2),
        .START_TIMEOUT(16),
        .MAX_TENURE   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .breq         (breq),
        .master_valid (master_valid),
        .txn_done     (txn_done),
        .bgrant       (bgrant),
        .owner        (owner),
        .bus_busy     (bus_busy),
        .timeout_pulse(timeout_pulse),
        .timeout_id   (timeout_id),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic [3:0] mv;
        logic       td;
        logic [3:0] eg;
        logic [1:0] eo;
        logic       eb;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample on the following falling edge.
    task automatic step(input logic r, input logic [3:0] b, input logic [3:0] mv, input logic td);
        logic [3:0] one_o;
        rst          = r;
        breq         = b;
        master_valid = mv;
        txn_done     = td;
        @(posedge clk);
        @(negedge clk);
        one_o = 4'b0001 << owner;
        check("grant_invariant",
              32'(((bgrant & (bgrant - 4'd1)) == 4'd0) && ((bgrant & ~one_o) == 4'd0)), 32'd1);
    endtask

    initial begin
        rst = 1'b1; breq = '0; master_valid = '0; txn_done = 1'b0;
        @(negedge clk);

        //          r   breq   mv     td    bgrant owner busy
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'h1, 4'h0, 1'b0, 4'h1, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h1, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'h1, 4'h0, 1'b0, 4'h1, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'h1, 4'h0, 1'b1, 4'h0, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h2, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h2, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 4'hD, 4'hF, 1'b0, 4'h0, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'hD, 4'h0, 1'b0, 4'h0, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 4'hD, 4'h0, 1'b0, 4'h4, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 4'h9, 4'h0, 1'b0, 4'h0, 2'd2, 1'b1};
        tbl[12] = '{1'b0, 4'h9, 4'h0, 1'b0, 4'h0, 2'd2, 1'b0};
        tbl[13] = '{1'b0, 4'h9, 4'h0, 1'b0, 4'h8, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 4'h9, 4'h0, 1'b1, 4'h8, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 4'h9, 4'h1, 1'b0, 4'h8, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 4'h9, 4'h8, 1'b0, 4'h8, 2'd3, 1'b1};
        tbl[17] = '{1'b0, 4'h9, 4'h8, 1'b1, 4'h0, 2'd3, 1'b1};
        tbl[18] = '{1'b1, 4'h9, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
        tbl[19] = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h1, 2'd0, 1'b1};
        tbl[20] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1};
        tbl[21] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].b, tbl[i].mv, tbl[i].td);
            check($sformatf("v%0d bgrant", i), 32'(bgrant), 32'(tbl[i].eg));
            check($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].eo));
            check($sformatf("v%0d bus_busy", i), 32'(bus_busy), 32'(tbl[i].eb));
            check($sformatf("v%0d timeout_pulse", i), 32'(timeout_pulse), 32'd0);
            check($sformatf("v%0d timeout_cnt", i), 32'(timeout_cnt), 32'd0);
        end

        // Round-robin rotation with all masters requesting.
        step(1'b1, 4'hF, 4'h0, 1'b0);
        step(1'b0, 4'hF, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr%0d bgrant", k), 32'(bgrant), 32'(1) << (k % 4));
            check($sformatf("rr%0d owner", k), 32'(owner), 32'(k % 4));
            step(1'b0, 4'hF, 4'hF, 1'b0);
            for (int j = 0; j < 4; j++) step(1'b0, 4'hF, 4'hF, 1'b0);
            check($sformatf("rr%0d busy_grant", k), 32'(bgrant), 32'(1) << (k % 4));
            step(1'b0, 4'hF, 4'hF, 1'b1);
            check($sformatf("rr%0d release_bgrant", k), 32'(bgrant), 32'd0);
            check($sformatf("rr%0d release_busy", k), 32'(bus_busy), 32'd1);
            step(1'b0, 4'hF, 4'hF, 1'b0);
            check($sformatf("rr%0d idle_bgrant", k), 32'(bgrant), 32'd0);
            check($sformatf("rr%0d idle_busy", k), 32'(bus_busy), 32'd0);
            step(1'b0, 4'hF, 4'hF, 1'b0);
        end

        // Start timeout: master 2 never raises master_valid.
        step(1'b1, 4'h4, 4'h0, 1'b0);
        step(1'b0, 4'h4, 4'h0, 1'b0);
        check("st owner", 32'(owner), 32'd2);
        check("st bgrant0", 32'(bgrant), 32'h4);
        for (int j = 1; j < 16; j++) begin
            step(1'b0, 4'h4, 4'h0, 1'b0);
            check($sformatf("st hold%0d", j), 32'({bgrant, timeout_pulse}), 32'({4'h4, 1'b0}));
        end
        step(1'b0, 4'h4, 4'h0, 1'b0);
        check("st bgrant_cleared", 32'(bgrant), 32'd0);
        check("st pulse", 32'(timeout_pulse), 32'd1);
        check("st id", 32'(timeout_id), 32'd2);
        check("st cnt", 32'(timeout_cnt), 32'd1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("st pulse_end", 32'(timeout_pulse), 32'd0);
        check("st id_hold", 32'(timeout_id), 32'd2);
        check("st busy_end", 32'(bus_busy), 32'd0);

        // Tenure timeout repeated until the counter saturates.
        step(1'b1, 4'h0, 4'h0, 1'b0);
        for (int it = 0; it < 300; it++) begin
            step(1'b0, 4'h2, 4'h2, 1'b0);
            check($sformatf("ten%0d owner", it), 32'(owner), 32'd1);
            step(1'b0, 4'h2, 4'h2, 1'b0);
            for (int j = 0; j < 63; j++) step(1'b0, 4'h2, 4'h2, 1'b0);
            if (it == 0) begin
                check("ten0 still_granted", 32'(bgrant), 32'h2);
                check("ten0 no_pulse_yet", 32'(timeout_pulse), 32'd0);
            end
            step(1'b0, 4'h2, 4'h2, 1'b0);
            check($sformatf("ten%0d release", it),
                  32'({bgrant, timeout_pulse, timeout_id}), 32'({4'h0, 1'b1, 2'd1}));
            check($sformatf("ten%0d cnt", it), 32'(timeout_cnt), (it + 1 > 255) ? 32'd255 : 32'(it + 1));
            step(1'b0, 4'h2, 4'h2, 1'b0);
            if (it == 0) check("ten0 pulse_end", 32'(timeout_pulse), 32'd0);
        end

        // txn_done on the last tenure cycle wins over the timeout.
        step(1'b0, 4'h2, 4'h0, 1'b0);
        step(1'b0, 4'h2, 4'h2, 1'b0);
        for (int j = 0; j < 63; j++) step(1'b0, 4'h2, 4'h2, 1'b0);
        step(1'b0, 4'h2, 4'h2, 1'b1);
        check("race bgrant", 32'(bgrant), 32'd0);
        check("race pulse", 32'(timeout_pulse), 32'd0);
        check("race cnt", 32'(timeout_cnt), 32'd255);
        check("race busy", 32'(bus_busy), 32'd1);
        step(1'b0, 4'h0, 4'h0, 1'b0);

        // Reset while master 3 is in BUSY.
        step(1'b0, 4'h8, 4'h0, 1'b0);
        check("rst owner3", 32'(owner), 32'd3);
        step(1'b0, 4'h8, 4'h8, 1'b0);
        step(1'b0, 4'h8, 4'h8, 1'b0);
        step(1'b1, 4'h8, 4'h8, 1'b0);
        check("rst bgrant", 32'(bgrant), 32'd0);
        check("rst owner", 32'(owner), 32'd0);
        check("rst busy", 32'(bus_busy), 32'd0);
        check("rst cnt", 32'(timeout_cnt), 32'd0);
        check("rst id", 32'(timeout_id), 32'd0);
        step(1'b0, 4'hF, 4'hF, 1'b0);
        check("rst first_grant", 32'(bgrant), 32'h1);
        check("rst first_owner", 32'(owner), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
